// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, holding byte, unload handshake and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose rx_parity_err.
module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_enable,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic [2:0] o_dbg_state
);

  // Handshake: a byte is available while rx_empty is low; a rising edge on
  // uld_rx_data consumes it and clears the sticky flags. A load arriving in
  // the same cycle as the unload edge wins, leaving rx_empty low.

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;
  logic [DW-1:0] r_div;
  logic          w_tick;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_wait_high;
  logic          w_wait_high_nxt;
  logic          w_stop_ok;
  logic          w_stop_bad;
  logic          w_par_bad;

  logic          r_load;
  logic          r_uld_d;
  logic          w_uld_edge;
  logic [7:0]    r_rx_data;
  logic          r_rx_empty;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_parity_err;

  assign w_rxs      = r_sync2;
  assign w_tick     = rx_enable && (r_div == DIV_LAST);
  assign w_uld_edge = uld_rx_data && !r_uld_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_div   <= '0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      if (!rx_enable || r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_wait_high <= w_wait_high_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_wait_high_nxt = r_wait_high;
    w_stop_ok       = 1'b0;
    w_stop_bad      = 1'b0;
    w_par_bad       = 1'b0;
    if (!rx_enable) begin
      w_state_nxt     = S_IDLE;
      w_cnt_nxt       = '0;
      w_bit_nxt       = '0;
      w_wait_high_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // After a bad stop bit the line may still be low; do not treat that as a new start.
          if (r_wait_high) begin
            if (w_rxs) w_wait_high_nxt = 1'b0;
          end else if (!w_rxs) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_cnt == HALF_LAST) begin
              if (w_rxs) begin
                w_state_nxt = S_IDLE;
              end else begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_DATA;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_cnt == BIT_LAST) begin
              w_cnt_nxt   = '0;
              w_shift_nxt = {w_rxs, r_shift[7:1]};
              if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                w_state_nxt = S_PARITY;
`else
                w_state_nxt = S_STOP;
`endif
              end else begin
                w_bit_nxt = r_bit + 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            if (r_cnt == BIT_LAST) begin
              w_cnt_nxt   = '0;
              w_par_bad   = ^{r_shift, w_rxs};
              w_state_nxt = S_STOP;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (r_cnt == BIT_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
              if (w_rxs) begin
                w_stop_ok = 1'b1;
              end else begin
                w_stop_bad      = 1'b1;
                w_wait_high_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Load takes effect one clock after the stop sample and is ordered after
  // the unload so it wins when both happen together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load       <= 1'b0;
      r_uld_d      <= 1'b0;
      r_rx_data    <= '0;
      r_rx_empty   <= 1'b1;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_load  <= w_stop_ok;
      r_uld_d <= uld_rx_data;
      if (w_uld_edge) begin
        r_rx_empty   <= 1'b1;
        r_frame_err  <= 1'b0;
        r_overrun    <= 1'b0;
        r_parity_err <= 1'b0;
      end
      if (r_load) begin
        r_rx_data  <= r_shift;
        r_rx_empty <= 1'b0;
        if (!r_rx_empty && !w_uld_edge) r_overrun <= 1'b1;
      end
      if (w_stop_bad) r_frame_err  <= 1'b1;
      if (w_par_bad)  r_parity_err <= 1'b1;
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_empty     = r_rx_empty;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign o_dbg_state  = r_state;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_parity_err;
`else
  logic w_unused;
  assign w_unused = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk per bit (DIV=1); one task per scenario.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_enable;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ST_IDLE = 3'd0;

  uart_rx #(
    .CLK_FREQ   (1600000),
    .BAUD       (100000),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_enable    (rx_enable),
    .uld_rx_data  (uld_rx_data),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_in = b;
    idle_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_val,
                            input int stop_clks);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par, 16);
`else
    if (par !== par) rx_in = 1'b1;
`endif
    send_bit(stop_val, stop_clks);
    rx_in = 1'b1;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    idle_clks(1);
    uld_rx_data = 1'b0;
    idle_clks(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_clks(3);
    reset = 1'b0;
    idle_clks(1);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", rx_empty); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", rx_overrun); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_basic();
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    fork
      send_frame(8'h55, ^8'h55, 1'b1, 16);
      begin
        while (!done && n < 300) begin
          idle_clks(1);
          n++;
          if (rx_empty === 1'b0) done = 1'b1;
        end
      end
    join
    idle_clks(8);
    checks++; if (!done || n < 154 || n > 156) begin errors++; $display("FAIL basic_latency got %0d exp 155+-1", n); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", rx_data); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", rx_empty); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b exp 0", rx_overrun); end
    unload();
  endtask

  task automatic test_unload();
    send_frame(8'hA3, ^8'hA3, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL uld_data got %h exp a3", rx_data); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL uld_full got %b exp 0", rx_empty); end
    unload();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL uld_empty got %b exp 1", rx_empty); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL uld_keep got %h exp a3", rx_data); end
    uld_rx_data = 1'b1;
    idle_clks(2);
    send_frame(8'h3C, ^8'h3C, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL uld_level got %b exp 0", rx_empty); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL uld_data2 got %h exp 3c", rx_data); end
    uld_rx_data = 1'b0;
    idle_clks(2);
    unload();
  endtask

  task automatic test_overrun();
    send_frame(8'h12, ^8'h12, 1'b1, 16);
    send_frame(8'h34, ^8'h34, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL ovr_data got %h exp 34", rx_data); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", rx_overrun); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL ovr_full got %b exp 0", rx_empty); end
    unload();
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", rx_overrun); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_empty got %b exp 1", rx_empty); end
  endtask

  task automatic test_frame_err();
    send_frame(8'hFF, ^8'hFF, 1'b0, 32);
    idle_clks(8);
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", rx_frame_err); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ferr_empty got %b exp 1", rx_empty); end
    checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL ferr_data got %h exp 34", rx_data); end
    send_frame(8'h0F, ^8'h0F, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL ferr_next got %h exp 0f", rx_data); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL ferr_next_empty got %b exp 0", rx_empty); end
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b exp 1", rx_frame_err); end
    unload();
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b exp 0", rx_frame_err); end
  endtask

  task automatic test_glitch();
    rx_in = 1'b0;
    idle_clks(4);
    rx_in = 1'b1;
    idle_clks(20);
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL glitch_state got %0d exp 0", dbg_state); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got %b exp 1", rx_empty); end
  endtask

  task automatic test_enable();
    fork
      send_frame(8'h81, ^8'h81, 1'b1, 16);
      begin
        idle_clks(80);
        rx_enable = 1'b0;
        idle_clks(2);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL en_state got %0d exp 0", dbg_state); end
      end
    join
    idle_clks(4);
    rx_enable = 1'b1;
    idle_clks(20);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL en_partial got %b exp 1", rx_empty); end
    send_frame(8'h81, ^8'h81, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL en_data got %h exp 81", rx_data); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL en_empty got %b exp 0", rx_empty); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL en_ovr got %b exp 0", rx_overrun); end
    unload();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL par_good got %b exp 0", rx_parity_err); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_good_data got %h exp 07", rx_data); end
    unload();
    send_frame(8'h07, 1'b0, 1'b1, 16);
    idle_clks(8);
    checks++; if (rx_parity_err !== 1'b1) begin errors++; $display("FAIL par_bad got %b exp 1", rx_parity_err); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_bad_data got %h exp 07", rx_data); end
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL par_bad_empty got %b exp 0", rx_empty); end
    unload();
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", rx_parity_err); end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    rx_in       = 1'b1;
    rx_enable   = 1'b1;
    uld_rx_data = 1'b0;
    test_reset();
    test_basic();
    test_unload();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_enable();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side UART for the FPGA serial link.
- Deserialises one 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit) from the RX pin into a holding byte, with empty/unload handshake, frame-error flag and overrun flag.
- Generates its own 16x oversampling tick from the system clock.
- Pairs with the existing transmit path: remote TX connects to rx_in.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be an even number, at least 8.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE), clocks per sample tick (truncating divide); must be at least 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_enable  input  1  receiver runs while high.
- uld_rx_data  input  1  a rising edge unloads the holding byte.
- rx_data  output  8  last correctly framed byte.
- rx_empty  output  1  high when no unread byte is held.
- rx_frame_err  output  1  sticky; stop bit sampled low.
- rx_overrun  output  1  sticky; a byte was received while rx_empty was 0.

Behaviour:
- Reset values: rx_data=0x00, rx_empty=1, rx_frame_err=0, rx_overrun=0.
- Reset internals: state IDLE, tick divider 0, sample counter 0, bit index 0, synchroniser flops 1, uld edge-detect flop 0.
- Synchroniser: rx_in passes through a 2-flop synchroniser. Only the synchronised value (rxs) is used; this adds 2 clk of input latency.
- Tick generator: one-cycle tick every DIV clocks. It is free-running while rx_enable=1 and held at 0 otherwise.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on rxs=0, clear the sample counter and go to START. Start detection is level-based; a line already low when enabled starts a frame.
- START: count OVERSAMPLE/2 ticks, then re-sample rxs.
  - rxs=1: false start, back to IDLE.
  - rxs=0: clear the counter, bit index=0, go to DATA.
- DATA: every OVERSAMPLE ticks, shift rxs into shift_reg[7] (right shift, so LSB-first arrival ends in bit 0).
  - After bit index 7, go to STOP.
- STOP: after OVERSAMPLE ticks, sample rxs.
  - rxs=1: on the next clk, rx_data<=shift_reg and rx_empty<=0. If rx_empty was already 0, set rx_overrun=1; the new byte overwrites the old one.
  - rxs=0: rx_frame_err<=1; rx_data and rx_empty are unchanged and the byte is discarded.
  - Either way go to IDLE. In the rxs=0 case the line is still low, so IDLE waits for rxs=1 before accepting a new start (flag wait_high, cleared when rxs=1).
- Unload: a rising edge of uld_rx_data (registered edge detect) sets rx_empty<=1 and clears rx_frame_err and rx_overrun. Level-held high has no further effect.
- Simultaneous byte load and unload edge in the same cycle: the load wins. Result is rx_empty=0, rx_overrun unchanged (not set), and both flags cleared by the unload.
- rx_enable=0: FSM forced to IDLE and any partial frame is discarded. Outputs hold their values and unload still works.
- Reset mid-frame: everything returns to reset values on the next clk; a partial frame is lost.
- Timing: rx_empty falls 1 clk after the stop-bit sample cycle. Nominal frame is 9.5 bit times from the start edge (at rxs) to the stop sample.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: a PARITY state between DATA and STOP samples one extra bit.
  - Adds output port rx_parity_err (1 bit, reset 0, sticky, cleared by unload). It is set when XOR(data bits, parity bit) is not 0.
  - The byte is still loaded if the stop bit is good.
- Undefined: no PARITY state, no rx_parity_err port, 8N1 only.

Test Plan:
All tests use CLK_FREQ=1600000, BAUD=100000, so DIV=1 and 16 clk per bit.
- Reset, then 0x55 sent 8N1 -> rx_data=0x55, rx_empty=0, both flags 0. rx_empty falls 2+152+1 clk after rx_in falls (±1).
- 0xA3 received, then an uld_rx_data pulse -> rx_empty=1 and rx_data stays 0xA3. Holding uld_rx_data high through a second byte 0x3C does not re-empty.
- Two bytes 0x12 then 0x34 with no unload -> rx_data=0x34, rx_overrun=1. Unload clears rx_overrun and sets rx_empty=1.
- Frame 0xFF with stop bit driven 0 for 32 clk -> rx_frame_err=1, rx_empty stays 1. A following 0x0F is received correctly after the line returns high.
- 4-clk low glitch on idle rx_in -> false start, no load, FSM in IDLE. rx_enable dropped mid-frame for 0x81, then a new 0x81 -> only the second frame loads.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> rx_parity_err=0. The same byte with parity bit 0 -> rx_parity_err=1, rx_data=0x07.
